// File: rtl/icache_assoc_datapath.sv
// rtl/icache_assoc_datapath.sv - N-way set-associative icache datapath (valid/tag/data arrays, hit, victim, fill)
//
// Holds the valid/tag/data arrays and detects hits across all ways. It picks a
// victim per set: the first invalid way, otherwise the set's round-robin pointer.
// It sequences critical-word-first, wrap-around line fills from L2. An external
// controller FSM drives all strobes.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   pipe_req_address             fetch address (held through a fill)
//   pipe_fetched_word            combinational read word
//   l2_req_address               word address of the current fill beat
//   l2_fetched_word              fill data from L2
//   load_mode                    steer reads/writes to the latched victim way and counter
//   perform_write                write l2_fetched_word into the fill slot
//   clear_selected_valid_bit     invalidate the latched victim way in the requested set
//   finish_new_line_install      mark victim valid, write tag, advance RR pointer
//   set_new_l2_block_address     latch {tag,set} and the victim way
//   reset_counter                start fill counter at the requested word
//   increment_counter            advance fill counter one beat
//   invalidate_all               flash-clear all valid bits
//   counter_done                 no fill beats remain
//   valid_block_match, hit_way   hit flag and lowest matching way
module icache_assoc_datapath #(
  parameter int LINE_SIZE  = 32,
  parameter int CACHE_SIZE = 1024,
  parameter int NUM_WAYS   = 2,
  parameter int XLEN       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pipe_req_address,
  output logic [XLEN-1:0]      pipe_fetched_word,
  output logic [XLEN-1:0]      l2_req_address,
  input  logic [XLEN-1:0]      l2_fetched_word,
  input  logic                 load_mode,
  input  logic                 perform_write,
  input  logic                 clear_selected_valid_bit,
  input  logic                 finish_new_line_install,
  input  logic                 set_new_l2_block_address,
  input  logic                 reset_counter,
  input  logic                 increment_counter,
  input  logic                 invalidate_all,
  output logic                 counter_done,
  output logic                 valid_block_match,
  output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] hit_way
);

  localparam int NUM_SETS = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
  localparam int WORDS    = LINE_SIZE / 4;
  localparam int OFS      = $clog2(LINE_SIZE);
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int TAG_W    = XLEN - SET_BITS - OFS;
  localparam int BLK_W    = XLEN - OFS;
  localparam int W        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int SI_W     = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int CW       = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (XLEN != 32) begin : g_bad_xlen
    $error("icache_assoc_datapath: only XLEN=32 is supported");
  end
  if (NUM_WAYS < 1 || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
    $error("icache_assoc_datapath: NUM_WAYS must be a power of 2 and >= 1");
  end
  if (LINE_SIZE < 4 || (LINE_SIZE & (LINE_SIZE - 1)) != 0) begin : g_bad_line
    $error("icache_assoc_datapath: LINE_SIZE must be a power of 2 and >= 4");
  end
  if (NUM_SETS < 1 || CACHE_SIZE != NUM_SETS * LINE_SIZE * NUM_WAYS) begin : g_bad_size
    $error("icache_assoc_datapath: CACHE_SIZE must be a multiple of LINE_SIZE*NUM_WAYS");
  end

  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [W-1:0]        rr_ptr_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]     data_q   [NUM_SETS][NUM_WAYS][WORDS];

  logic [W-1:0]        victim_q;
  logic [BLK_W-1:0]    l2_block_q;
  logic [CW-1:0]       counter_q;
  logic [CW-1:0]       beats_left_q;

  // Shift-and-mask decode keeps a one-set or one-word geometry elaborating cleanly.
  logic [SI_W-1:0]  req_set;
  logic [TAG_W-1:0] req_tag;
  logic [CW-1:0]    req_word;
  assign req_set  = SI_W'((pipe_req_address >> OFS) & XLEN'(NUM_SETS - 1));
  assign req_tag  = TAG_W'(pipe_req_address >> (OFS + SET_BITS));
  assign req_word = CW'((pipe_req_address >> 2) & XLEN'(WORDS - 1));

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    valid_block_match = 1'b0;
    hit_way           = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid_q[req_set][i] && tag_q[req_set][i] == req_tag) begin
        valid_block_match = 1'b1;
        hit_way           = W'(i);
      end
    end
  end

  logic [W-1:0] victim_sel;
  always_comb begin
    victim_sel = rr_ptr_q[req_set];
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_q[req_set][i]) victim_sel = W'(i);
    end
  end

  logic [W-1:0]  rd_way;
  logic [CW-1:0] rd_word;
  assign rd_way            = load_mode ? victim_q  : hit_way;
  assign rd_word           = load_mode ? counter_q : req_word;
  assign pipe_fetched_word = data_q[req_set][rd_way][rd_word];

  assign counter_done   = (beats_left_q == '0);
  assign l2_req_address = (XLEN'(l2_block_q) << OFS) | (XLEN'(counter_q) << 2);

  logic [W-1:0] rr_next;
  assign rr_next = W'((32'(rr_ptr_q[req_set]) + 32'd1) & 32'(NUM_WAYS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
    end else if (invalidate_all) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (clear_selected_valid_bit) begin
      valid_q[req_set][victim_q] <= 1'b0;
    end else if (finish_new_line_install) begin
      valid_q[req_set][victim_q] <= 1'b1;
      tag_q[req_set][victim_q]   <= req_tag;
      rr_ptr_q[req_set]          <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      victim_q   <= '0;
      l2_block_q <= '0;
    end else if (set_new_l2_block_address) begin
      victim_q   <= victim_sel;
      l2_block_q <= BLK_W'(pipe_req_address >> OFS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q    <= '0;
      beats_left_q <= '0;
    end else if (reset_counter) begin
      counter_q    <= req_word;
      beats_left_q <= CW'(WORDS - 1);
    end else if (increment_counter && beats_left_q != '0) begin
      counter_q    <= CW'((32'(counter_q) + 32'd1) & 32'(WORDS - 1));
      beats_left_q <= beats_left_q - 1'b1;
    end
  end

  // Data is deliberately not reset; an aborted fill leaves its words behind an invalid line.
  always_ff @(posedge clk) begin
    if (perform_write && load_mode) begin
      data_q[req_set][victim_q][counter_q] <= l2_fetched_word;
    end
  end

endmodule
